// File: rtl/text_console_writer.sv
// Character-stream to text-VRAM writer: cursor tracking, control-code handling,
// byte-lane glyph packing, scroll-up on overflow and full/row clears over Avalon-MM.
module text_console_writer #(
   parameter int unsigned COLS           = 80,
   parameter int unsigned ROWS           = 30,
   parameter int unsigned WPR            = COLS / 4,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        CLK_100,
   input  logic        RESET,
   input  logic [7:0]  CHAR_DATA,
   input  logic        CHAR_INV,
   input  logic        CHAR_VALID,
   output logic        CHAR_READY,
   output logic [9:0]  M_ADDR,
   output logic        M_READ,
   output logic        M_WRITE,
   output logic [3:0]  M_BYTE_EN,
   output logic [31:0] M_WRITEDATA,
   input  logic [31:0] M_READDATA,
   input  logic        M_WAITREQUEST,
   input  logic        M_READDATAVALID,
   output logic [6:0]  CURSOR_COL,
   output logic [4:0]  CURSOR_ROW,
   output logic        BUSY
);

   localparam int unsigned AW            = 10;
   localparam logic [AW-1:0] WPR_A        = AW'(WPR);
   localparam logic [AW-1:0] SCROLL_LAST  = AW'((ROWS - 1) * WPR - 1);
   localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * WPR);
   localparam logic [AW-1:0] LAST_WORD    = AW'(ROWS * WPR - 1);
   localparam logic [6:0]    COL_LAST     = 7'(COLS - 1);
   localparam logic [4:0]    ROW_LAST     = 5'(ROWS - 1);
   localparam logic [31:0]   BLANK        = 32'h2020_2020;

   typedef enum logic [2:0] {
      ST_CLR_ALL, ST_IDLE, ST_WR_CHAR, ST_SC_RD, ST_SC_WAIT, ST_SC_WR, ST_CLR_ROW
   } state_t;

   state_t         state_q;
   logic [6:0]     col_q;
   logic [4:0]     row_q;
   logic [AW-1:0]  idx_q;
   logic [AW-1:0]  m_addr_q;
   logic           m_read_q;
   logic           m_write_q;
   logic [3:0]     m_be_q;
   logic [31:0]    m_wdata_q;
   logic           char_ready_q;
   logic           busy_q;

   logic           accept_c;
   logic           printable_c;
   logic [7:0]     lane_c;
   logic [AW-1:0]  char_addr_c;

   assign accept_c    = (state_q == ST_IDLE) && char_ready_q && CHAR_VALID;
   assign printable_c = (CHAR_DATA >= 8'h20) && (CHAR_DATA != 8'h7F);
   assign lane_c      = {CHAR_INV, CHAR_DATA[6:0]};
   assign char_addr_c = AW'(row_q) * WPR_A + AW'(col_q[6:2]);

   always_ff @(posedge CLK_100 or posedge RESET) begin
      if (RESET) begin
         state_q      <= CLEAR_ON_RESET ? ST_CLR_ALL : ST_IDLE;
         busy_q       <= CLEAR_ON_RESET;
         col_q        <= '0;
         row_q        <= '0;
         idx_q        <= '0;
         m_addr_q     <= '0;
         m_read_q     <= 1'b0;
         m_write_q    <= 1'b0;
         m_be_q       <= '0;
         m_wdata_q    <= '0;
         char_ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               char_ready_q <= 1'b1;
               if (accept_c) begin
                  if (printable_c) begin
                     m_write_q    <= 1'b1;
                     m_addr_q     <= char_addr_c;
                     m_be_q       <= 4'b0001 << col_q[1:0];
                     m_wdata_q    <= {4{lane_c}};
                     state_q      <= ST_WR_CHAR;
                     busy_q       <= 1'b1;
                     char_ready_q <= 1'b0;
                  end else if (CHAR_DATA == 8'h0D) begin
                     col_q <= '0;
                  end else if (CHAR_DATA == 8'h0A) begin
                     col_q <= '0;
                     if (row_q == ROW_LAST) begin
                        m_read_q     <= 1'b1;
                        m_addr_q     <= WPR_A;
                        idx_q        <= '0;
                        state_q      <= ST_SC_RD;
                        busy_q       <= 1'b1;
                        char_ready_q <= 1'b0;
                     end else begin
                        row_q <= row_q + 5'd1;
                     end
                  end else if (CHAR_DATA == 8'h08) begin
                     if (col_q != 7'd0) col_q <= col_q - 7'd1;
                  end else if (CHAR_DATA == 8'h0C) begin
                     col_q        <= '0;
                     row_q        <= '0;
                     idx_q        <= '0;
                     state_q      <= ST_CLR_ALL;
                     busy_q       <= 1'b1;
                     char_ready_q <= 1'b0;
                  end
               end
            end

            // Glyph write; cursor advances only once the slave takes it.
            ST_WR_CHAR: begin
               if (!M_WAITREQUEST) begin
                  m_write_q <= 1'b0;
                  if (col_q == COL_LAST && row_q == ROW_LAST) begin
                     col_q    <= '0;
                     m_read_q <= 1'b1;
                     m_addr_q <= WPR_A;
                     idx_q    <= '0;
                     state_q  <= ST_SC_RD;
                  end else begin
                     if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + 5'd1;
                     end else begin
                        col_q <= col_q + 7'd1;
                     end
                     state_q      <= ST_IDLE;
                     busy_q       <= 1'b0;
                     char_ready_q <= 1'b1;
                  end
               end
            end

            ST_SC_RD: begin
               if (!M_WAITREQUEST) begin
                  m_read_q <= 1'b0;
                  state_q  <= ST_SC_WAIT;
               end
            end

            ST_SC_WAIT: begin
               if (M_READDATAVALID) begin
                  m_write_q <= 1'b1;
                  m_addr_q  <= idx_q;
                  m_wdata_q <= M_READDATA;
                  m_be_q    <= 4'hF;
                  state_q   <= ST_SC_WR;
               end
            end

            // Copy-back of one word; the last one hands over to the bottom-row clear.
            ST_SC_WR: begin
               if (!M_WAITREQUEST) begin
                  if (idx_q == SCROLL_LAST) begin
                     idx_q     <= LAST_ROW_BASE;
                     m_addr_q  <= LAST_ROW_BASE;
                     m_wdata_q <= BLANK;
                     state_q   <= ST_CLR_ROW;
                  end else begin
                     m_write_q <= 1'b0;
                     m_read_q  <= 1'b1;
                     idx_q     <= idx_q + 10'd1;
                     m_addr_q  <= idx_q + 10'd1 + WPR_A;
                     state_q   <= ST_SC_RD;
                  end
               end
            end

            ST_CLR_ALL, ST_CLR_ROW: begin
               if (!m_write_q) begin
                  m_write_q <= 1'b1;
                  m_addr_q  <= idx_q;
                  m_wdata_q <= BLANK;
                  m_be_q    <= 4'hF;
               end else if (!M_WAITREQUEST) begin
                  if (idx_q == LAST_WORD) begin
                     m_write_q    <= 1'b0;
                     idx_q        <= '0;
                     state_q      <= ST_IDLE;
                     busy_q       <= 1'b0;
                     char_ready_q <= 1'b1;
                  end else begin
                     idx_q    <= idx_q + 10'd1;
                     m_addr_q <= idx_q + 10'd1;
                  end
               end
            end

            default: begin
               m_read_q  <= 1'b0;
               m_write_q <= 1'b0;
               state_q   <= ST_IDLE;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign CHAR_READY  = char_ready_q;
   assign M_ADDR      = m_addr_q;
   assign M_READ      = m_read_q;
   assign M_WRITE     = m_write_q;
   assign M_BYTE_EN   = m_be_q;
   assign M_WRITEDATA = m_wdata_q;
   assign CURSOR_COL  = col_q;
   assign CURSOR_ROW  = row_q;
   assign BUSY        = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: vector table for single characters,
// scoreboard of expected VRAM writes, plus stall, scroll, clear and reset sequences.
module tb_text_console_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  char_data;
   logic        char_inv;
   logic        char_valid;
   logic        char_ready;
   logic [9:0]  m_addr;
   logic        m_read;
   logic        m_write;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = '0;
   logic        waitreq;
   logic        rdv = 1'b0;
   logic [6:0]  cur_col;
   logic [4:0]  cur_row;
   logic        busy;

   text_console_writer dut (
      .CLK_100(clk), .RESET(rst),
      .CHAR_DATA(char_data), .CHAR_INV(char_inv), .CHAR_VALID(char_valid), .CHAR_READY(char_ready),
      .M_ADDR(m_addr), .M_READ(m_read), .M_WRITE(m_write), .M_BYTE_EN(m_be),
      .M_WRITEDATA(m_wdata), .M_READDATA(m_rdata), .M_WAITREQUEST(waitreq),
      .M_READDATAVALID(rdv), .CURSOR_COL(cur_col), .CURSOR_ROW(cur_row), .BUSY(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [7:0]  code;
      logic        inv;
      logic        wr;
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
      int          col;
      int          row;
   } vec_t;

   wr_t  exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_writes = 0;
   int   n_reads  = 0;
   bit   sb_en    = 1'b1;
   int   tb_col   = 0;
   int   tb_row   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave: returns the read address as data, valid one cycle after the read completes
   always @(posedge clk) begin
      rdv     <= !rst && m_read && !waitreq;
      m_rdata <= {22'd0, m_addr};
   end

   // Monitor: every completed write is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (!rst) begin
         if (m_read && !waitreq) n_reads++;
         if (m_write && !waitreq) begin
            n_writes++;
            if (sb_en) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", m_addr, m_wdata);
               end else begin
                  wr_t e;
                  e = exp_q.pop_front();
                  check("wr_addr", 32'(m_addr), 32'(e.addr));
                  check("wr_be",   32'(m_be),   32'(e.be));
                  check("wr_data", m_wdata,     e.data);
               end
            end
         end
      end
   end

   task automatic send_char(input logic [7:0] code, input logic inv);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      char_data  = code;
      char_inv   = inv;
      char_valid = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (char_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      char_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got CHAR_READY=0, expected 1 within 5000 cycles");
      end
   endtask

   task automatic wait_ready(input int max_cycles);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (char_ready) begin ok = 1'b1; break; end
      end
      check("ready_timeout", 32'(ok), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_cursor(input string name, input int col, input int row);
      check({name, "_col"}, 32'(cur_col), 32'(col));
      check({name, "_row"}, 32'(cur_row), 32'(row));
   endtask

   task automatic push_blank(input int first, input int count);
      for (int k = 0; k < count; k++) exp_q.push_back({10'(first + k), 4'hF, 32'h2020_2020});
   endtask

   task automatic print(input logic [7:0] code, input logic inv);
      logic [7:0] lane;
      lane = {inv, code[6:0]};
      exp_q.push_back({10'(tb_row * 20 + tb_col / 4), 4'(1 << (tb_col % 4)), {4{lane}}});
      send_char(code, inv);
      wait_ready(20);
      tb_col++;
      if (tb_col == 80) begin tb_col = 0; tb_row++; end
   endtask

   task automatic lf();
      send_char(8'h0A, 1'b0);
      wait_ready(20);
      tb_col = 0;
      tb_row++;
   endtask

   vec_t vecs[15];

   initial begin
      int wr0, rd0;
      logic [9:0]  a0;
      logic [3:0]  b0;
      logic [31:0] d0;
      bit          was_reading;

      vecs[0]  = '{8'h41, 1'b0, 1'b1, 10'd0,  4'h1, 32'h4141_4141, 1, 0};
      vecs[1]  = '{8'h42, 1'b1, 1'b1, 10'd0,  4'h2, 32'hC2C2_C2C2, 2, 0};
      vecs[2]  = '{8'h0D, 1'b0, 1'b0, 10'd0,  4'h0, 32'h0,         0, 0};
      vecs[3]  = '{8'hC1, 1'b0, 1'b1, 10'd0,  4'h1, 32'h4141_4141, 1, 0};
      vecs[4]  = '{8'h7F, 1'b0, 1'b0, 10'd0,  4'h0, 32'h0,         1, 0};
      vecs[5]  = '{8'h0A, 1'b0, 1'b0, 10'd0,  4'h0, 32'h0,         0, 1};
      vecs[6]  = '{8'h08, 1'b0, 1'b0, 10'd0,  4'h0, 32'h0,         0, 1};
      vecs[7]  = '{8'h20, 1'b1, 1'b1, 10'd20, 4'h1, 32'hA0A0_A0A0, 1, 1};
      vecs[8]  = '{8'h08, 1'b0, 1'b0, 10'd0,  4'h0, 32'h0,         0, 1};
      vecs[9]  = '{8'h01, 1'b0, 1'b0, 10'd0,  4'h0, 32'h0,         0, 1};
      vecs[10] = '{8'hFF, 1'b0, 1'b1, 10'd20, 4'h1, 32'h7F7F_7F7F, 1, 1};
      vecs[11] = '{8'h7E, 1'b1, 1'b1, 10'd20, 4'h2, 32'hFEFE_FEFE, 2, 1};
      vecs[12] = '{8'h33, 1'b0, 1'b1, 10'd20, 4'h4, 32'h3333_3333, 3, 1};
      vecs[13] = '{8'h34, 1'b0, 1'b1, 10'd20, 4'h8, 32'h3434_3434, 4, 1};
      vecs[14] = '{8'h35, 1'b0, 1'b1, 10'd21, 4'h1, 32'h3535_3535, 5, 1};

      rst = 1'b1; waitreq = 1'b0; char_valid = 1'b0; char_data = '0; char_inv = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_write", 32'(m_write), 32'd0);
      check("rst_read",  32'(m_read),  32'd0);
      check("rst_addr",  32'(m_addr),  32'd0);
      check("rst_be",    32'(m_be),    32'd0);
      check("rst_wdata", m_wdata,      32'd0);
      check("rst_busy",  32'(busy),    32'd1);
      check("rst_ready", 32'(char_ready), 32'd0);
      check_cursor("rst", 0, 0);

      push_blank(0, 600);
      @(posedge clk); #1 rst = 1'b0;
      wait_ready(2000);
      check("clear_count", 32'(n_writes), 32'd600);
      check("idle_busy", 32'(busy), 32'd0);
      check_cursor("after_clear", 0, 0);

      foreach (vecs[i]) begin
         if (vecs[i].wr) exp_q.push_back({vecs[i].addr, vecs[i].be, vecs[i].data});
         send_char(vecs[i].code, vecs[i].inv);
         wait_ready(20);
         check_cursor($sformatf("vec%0d", i), vecs[i].col, vecs[i].row);
      end
      tb_col = 5; tb_row = 1;

      // CR at (40,3) must produce no bus traffic; BS at column 0 holds
      send_char(8'h0D, 1'b0); wait_ready(20); tb_col = 0;
      lf(); lf();
      for (int c = 0; c < 40; c++) print(8'h61 + 8'(c % 26), 1'b0);
      check_cursor("pre_cr", 40, 3);
      wr0 = n_writes; rd0 = n_reads;
      send_char(8'h0D, 1'b0); wait_ready(20);
      repeat (3) @(negedge clk);
      check("cr_no_write", 32'(n_writes - wr0), 32'd0);
      check("cr_no_read",  32'(n_reads - rd0),  32'd0);
      check_cursor("cr", 0, 3);
      send_char(8'h08, 1'b0); wait_ready(20);
      check_cursor("bs_col0", 0, 3);
      tb_col = 0;

      // Right edge of row 5 wraps to the next row
      lf(); lf();
      for (int c = 0; c < 79; c++) print(8'h30 + 8'(c % 10), 1'b0);
      check_cursor("pre_wrap", 79, 5);
      exp_q.push_back({10'd119, 4'h8, 32'h4141_4141});
      send_char(8'h41, 1'b0); wait_ready(20);
      check_cursor("wrap", 0, 6);
      tb_col = 0; tb_row = 6;

      // Stalled glyph write: command held stable for 6 cycles, completes once
      @(posedge clk); #1 waitreq = 1'b1;
      wr0 = n_writes;
      exp_q.push_back({10'd120, 4'h1, 32'h5A5A_5A5A});
      send_char(8'h5A, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) begin a0 = m_addr; b0 = m_be; d0 = m_wdata; end
         check("stall_write", 32'(m_write), 32'd1);
         check("stall_addr",  32'(m_addr),  32'(a0));
         check("stall_be",    32'(m_be),    32'(b0));
         check("stall_data",  m_wdata,      d0);
         if (i == 4) begin @(posedge clk); #1 waitreq = 1'b0; end
      end
      wait_ready(20);
      check("stall_one_write", 32'(n_writes - wr0), 32'd1);
      check_cursor("stall", 1, 6);
      tb_col = 1;

      // LF at (10,29) scrolls: read k+20 written to k, then bottom row blanked
      send_char(8'h0D, 1'b0); wait_ready(20); tb_col = 0;
      for (int r = 0; r < 23; r++) lf();
      for (int c = 0; c < 10; c++) print(8'h4B, 1'b1);
      check_cursor("pre_scroll", 10, 29);
      rd0 = n_reads;
      for (int k = 0; k < 580; k++) exp_q.push_back({10'(k), 4'hF, 32'(k + 20)});
      push_blank(580, 20);
      send_char(8'h0A, 1'b0);
      wait_ready(4000);
      check("scroll_reads", 32'(n_reads - rd0), 32'd580);
      check_cursor("scroll", 0, 29);

      // Form feed clears everything and homes the cursor
      push_blank(0, 600);
      send_char(8'h0C, 1'b0);
      wait_ready(2000);
      check_cursor("ff", 0, 0);
      tb_col = 0; tb_row = 0;

      // Reset in the middle of a scroll drops the bus strobes immediately
      sb_en = 1'b0;
      for (int r = 0; r < 29; r++) lf();
      send_char(8'h0A, 1'b0);
      repeat (40) @(posedge clk);
      was_reading = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (m_read) begin was_reading = 1'b1; break; end
      end
      check("midscroll_read", 32'(was_reading), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_read",  32'(m_read),  32'd0);
      check("abort_write", 32'(m_write), 32'd0);
      check("abort_busy",  32'(busy),    32'd1);
      check("abort_ready", 32'(char_ready), 32'd0);
      check_cursor("abort", 0, 0);
      exp_q.delete();
      sb_en = 1'b1;
      push_blank(0, 600);
      @(posedge clk); #1 rst = 1'b0;
      wait_ready(2000);
      check_cursor("reclear", 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
